// File: rtl/booth_multiplier_seq.sv
// booth_multiplier_seq: iterative radix-4 Booth multiplier, one digit per clock.
// Signed/unsigned operands per operation, valid/ready handshakes on both sides.
// Optional macro BOOTH_MUL_EARLY_TERM_EN: finish as soon as all remaining
// Booth digits are zero.
module booth_multiplier_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam int NSTEP = WIDTH / 2 + 1;
    localparam int XW    = WIDTH + 2;
    localparam int YW    = WIDTH + 3;
    localparam int PW    = 2 * WIDTH;
    localparam int SW    = $clog2(NSTEP);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t          state, state_nxt;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic [YW-1:0]   y_shift;
    // Accumulator is kept at product width: bits above 2*WIDTH never reach
    // the product, and two's-complement addition is exact modulo 2^PW.
    logic [PW-1:0]   acc;
    logic [PW-1:0]   x_ext;
    logic [PW-1:0]   pp;
    logic [SW-1:0]   step;
    logic            accept;
    logic            calc_end;

    assign accept  = in_valid && in_ready;
    assign product = acc;

    // Booth digit decode, partial product and end-of-calculation detect
    always_comb begin
        x_ext = {{(PW-XW){x[XW-1]}}, x};
        case (y[2:0])
            3'b001, 3'b010: pp = x_ext;
            3'b011:         pp = x_ext << 1;
            3'b100:         pp = -(x_ext << 1);
            3'b101, 3'b110: pp = -x_ext;
            default:        pp = '0;
        endcase
        y_shift  = $signed(y) >>> 2;
        calc_end = (step == SW'(NSTEP - 1));
`ifdef BOOTH_MUL_EARLY_TERM_EN
        if ((y_shift == '0) || (y_shift == '1)) begin
            calc_end = 1'b1;
        end
`endif
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = CALC;
            CALC: if (calc_end) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = accept ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
        out_valid = (state == DONE);
    end

    // Operand latch and per-step accumulate/shift
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x    <= '0;
            y    <= '0;
            acc  <= '0;
            step <= '0;
        end else if (accept) begin
            x    <= is_signed ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
            y    <= {(is_signed ? {{2{b[WIDTH-1]}}, b} : {2'b00, b}), 1'b0};
            acc  <= '0;
            step <= '0;
        end else if (state == CALC) begin
            acc  <= acc + (pp << {step, 1'b0});
            y    <= y_shift;
            step <= step + 1'b1;
        end
    end

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Self-checking bench for booth_multiplier_seq at WIDTH=16 and WIDTH=8.
// Products and latencies come from an integer reference model; latency
// follows BOOTH_MUL_EARLY_TERM_EN when that macro is defined.
module tb_booth_multiplier_seq;

`ifdef BOOTH_MUL_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        iv16, ir16, sg16, ov16, or16;
    logic [15:0] a16, b16;
    logic [31:0] p16;
    logic        iv8, ir8, sg8, ov8, or8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    int checks   = 0;
    int failures = 0;

    booth_multiplier_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
        .is_signed(sg16), .a(a16), .b(b16), .out_valid(ov16),
        .out_ready(or16), .product(p16)
    );

    booth_multiplier_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
        .is_signed(sg8), .a(a8), .b(b8), .out_valid(ov8),
        .out_ready(or8), .product(p8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic longint to_int(input int w, input bit s, input logic [31:0] v);
        longint r;
        r = longint'(v);
        if (s && v[w-1]) r = r - (longint'(1) << w);
        return r;
    endfunction

    function automatic logic [63:0] ref_mul(input int w, input bit s,
                                            input logic [31:0] aa, input logic [31:0] bb);
        longint pr;
        pr = to_int(w, s, aa) * to_int(w, s, bb);
        return 64'(pr) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    // Cycles from handshake to out_valid: NSTEP, or with early termination the
    // first digit count after which the remaining multiplier is all 0s or all 1s.
    function automatic int ref_lat(input int w, input bit s, input logic [31:0] bb);
        int     nstep;
        longint yv;
        nstep = w / 2 + 1;
        yv    = to_int(w, s, bb) * 2;
        for (int k = 1; k < nstep; k++) begin
            if (EARLY && (((yv >>> (2 * k)) == 0) || ((yv >>> (2 * k)) == -1))) return k;
        end
        return nstep;
    endfunction

    // ---------------- WIDTH=16 helpers ----------------
    task automatic start16(input bit s, input logic [15:0] aa, input logic [15:0] bb);
        @(negedge clk);
        sg16 = s; a16 = aa; b16 = bb; iv16 = 1'b1;
        check("in_ready16", ir16, 1);
        @(posedge clk);
        @(negedge clk);
        iv16 = 1'b0;
    endtask

    task automatic wait16(input string tag, input logic [31:0] exp, input int lat);
        int cnt = 0;
        while (!ov16 && cnt < 64) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, "_lat"}, cnt, lat);
        check({tag, "_prod"}, p16, exp);
    endtask

    task automatic release16();
        or16 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        or16 = 1'b0;
    endtask

    task automatic op16(input string tag, input bit s, input logic [15:0] aa, input logic [15:0] bb);
        start16(s, aa, bb);
        wait16(tag, ref_mul(16, s, aa, bb), ref_lat(16, s, bb));
        release16();
    endtask

    // ---------------- WIDTH=8 helpers ----------------
    task automatic op8(input string tag, input bit s, input logic [7:0] aa, input logic [7:0] bb);
        int cnt = 0;
        @(negedge clk);
        sg8 = s; a8 = aa; b8 = bb; iv8 = 1'b1;
        check("in_ready8", ir8, 1);
        @(posedge clk);
        @(negedge clk);
        iv8 = 1'b0;
        while (!ov8 && cnt < 64) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, "_lat"}, cnt, ref_lat(8, s, bb));
        check({tag, "_prod"}, p8, ref_mul(8, s, aa, bb));
        or8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        or8 = 1'b0;
    endtask

    initial begin
        logic [7:0] corners [5];
        bit         seen_ov;
        corners = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};

        rst  = 1'b1;
        iv16 = 1'b0; sg16 = 1'b0; a16 = '0; b16 = '0; or16 = 1'b0;
        iv8  = 1'b0; sg8  = 1'b0; a8  = '0; b8  = '0; or8  = 1'b0;
        #12;
        check("rst_ir16", ir16, 1);
        check("rst_ov16", ov16, 0);
        check("rst_p16", p16, 0);
        check("rst_ir8", ir8, 1);
        check("rst_ov8", ov8, 0);
        @(negedge clk);
        rst = 1'b0;

        // Corner products with fixed expectations
        start16(1'b1, 16'h8000, 16'h8000);
        wait16("mneg", 32'h4000_0000, ref_lat(16, 1'b1, 32'h8000));
        release16();
        start16(1'b0, 16'hFFFF, 16'hFFFF);
        wait16("ones_u", 32'hFFFE_0001, ref_lat(16, 1'b0, 32'hFFFF));
        release16();
        start16(1'b1, 16'hFFFF, 16'hFFFF);
        wait16("ones_s", 32'h0000_0001, ref_lat(16, 1'b1, 32'hFFFF));
        release16();

        // Output stall, then same-edge bypass into the next operation
        start16(1'b1, 16'hFFFF, 16'h0002);
        wait16("m1x2", 32'hFFFF_FFFE, ref_lat(16, 1'b1, 32'h0002));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_prod", p16, 32'hFFFF_FFFE);
            check("stall_ov", ov16, 1);
            check("stall_ir", ir16, 0);
        end
        or16 = 1'b1; iv16 = 1'b1; sg16 = 1'b1; a16 = 16'd3; b16 = 16'd5;
        #1;
        check("bypass_ir", ir16, 1);
        @(posedge clk);
        @(negedge clk);
        or16 = 1'b0; iv16 = 1'b0;
        check("bypass_ov", ov16, 0);
        wait16("bypass", 32'h0000_000F, ref_lat(16, 1'b1, 32'd5));
        release16();

        // Reset four cycles into CALC discards the operation
        start16(1'b0, 16'd1234, 16'd4321);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_ir", ir16, 1);
        check("midrst_ov", ov16, 0);
        check("midrst_p", p16, 0);
        @(negedge clk);
        rst = 1'b0;
        seen_ov = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (ov16) seen_ov = 1'b1;
        end
        check("midrst_no_ov", seen_ov, 0);
        start16(1'b0, 16'd100, 16'd200);
        wait16("post_rst", 32'h0000_4E20, ref_lat(16, 1'b0, 32'd200));
        release16();

        // Early-termination candidates (fixed latency when the macro is off)
        start16(1'b1, 16'h1234, 16'h0003);
        wait16("et_x3", 32'h0000_369C, ref_lat(16, 1'b1, 32'h0003));
        release16();
        start16(1'b1, 16'h1234, 16'h0000);
        wait16("et_x0", 32'h0000_0000, ref_lat(16, 1'b1, 32'h0000));
        release16();

        // Random WIDTH=16 operations
        for (int i = 0; i < 300; i++) begin
            op16("r16", 1'($urandom), 16'($urandom), 16'($urandom));
        end

        // WIDTH=8: corner grid in both modes, then random sweep
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 5; i++) begin
                for (int j = 0; j < 5; j++) begin
                    op8("c8", 1'(s), corners[i], corners[j]);
                end
            end
        end
        for (int i = 0; i < 3000; i++) begin
            op8("r8", 1'($urandom), 8'($urandom), 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
